jpeg_coef_buf: RTL and testbench



---
 rtl/jpeg_pkg.sv | 18 +
 rtl/jpeg_coef_buf_ram.sv | 45 ++++
 rtl/jpeg_coef_buf.sv | 177 +++++++++++++++++
 tb/tb_jpeg_coef_buf.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG coefficient path: block geometry, word
// widths and the read-side state encoding of the coefficient buffer.
package jpeg_pkg;

    localparam int JPEG_BLK_SIZE = 64;
    localparam int JPEG_COEF_W   = 16;
    localparam int JPEG_ID_W     = 32;
    localparam int JPEG_IDX_W    = 6;
    // One extra address bit selects the ping-pong bank.
    localparam int JPEG_RAM_AW   = JPEG_IDX_W + 1;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

endpackage : jpeg_pkg

// File: rtl/jpeg_coef_buf_ram.sv
// 128x16 coefficient store, addressed {bank, idx}. One write port and one
// synchronous read port. The read data register doubles as the output
// holding register of the buffer: it only reloads on rd_en_i, so a stalled
// beat stays on the bus. rd_zero_i substitutes zero for indices that were
// never written in the current block.
module jpeg_coef_buf_ram
    import jpeg_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [JPEG_RAM_AW-1:0] wr_addr_i,
    input  logic [JPEG_COEF_W-1:0] wr_data_i,
    input  logic                   rd_en_i,
    input  logic                   rd_zero_i,
    input  logic                   rd_clr_i,
    input  logic [JPEG_RAM_AW-1:0] rd_addr_i,
    output logic [JPEG_COEF_W-1:0] rd_data_o
);

    logic [JPEG_COEF_W-1:0] mem_q [2*JPEG_BLK_SIZE];

    // Array write port.
    // NOTE: the storage array has no reset; stale words are masked by the
    // per-bank written-mask, and leaving it unreset keeps it RAM-inferable.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read data register: loads the addressed word (or zero) on a read.
    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o <= '0;
        end else if (rd_clr_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= rd_zero_i ? '0 : mem_q[rd_addr_i];
        end
    end

endmodule : jpeg_coef_buf_ram

// File: rtl/jpeg_coef_buf.sv
// Ping-pong 8x8 coefficient buffer between dequantiser and IDCT.
// Captures sparse coefficients into one bank while the other bank is
// replayed as a dense 64-beat stream with valid/accept flow control.
// Build option: define JPEG_COEF_BUF_TRANSPOSE_EN to replay each block in
// column-major order (outport_idx_o then reports the transposed index).
module jpeg_coef_buf
    import jpeg_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   img_start_i,
    input  logic                   inport_valid_i,
    input  logic [JPEG_COEF_W-1:0] inport_data_i,
    input  logic [JPEG_IDX_W-1:0]  inport_idx_i,
    input  logic [JPEG_ID_W-1:0]   inport_id_i,
    input  logic                   inport_eob_i,
    output logic                   inport_blk_space_o,
    output logic                   outport_valid_o,
    output logic [JPEG_COEF_W-1:0] outport_data_o,
    output logic [JPEG_IDX_W-1:0]  outport_idx_o,
    output logic [JPEG_ID_W-1:0]   outport_id_o,
    output logic                   outport_last_o,
    input  logic                   outport_accept_i
);

    // Per-bank bookkeeping.
    logic [1:0]                full_q;
    logic [JPEG_BLK_SIZE-1:0]  mask_q [2];
    logic [JPEG_ID_W-1:0]      id_q   [2];
    logic                      wr_bank_q;
    logic                      rd_bank_q;

    // Read side.
    rd_state_e                 state_q, state_d;
    logic [JPEG_IDX_W-1:0]     rd_cnt_q;
    logic [JPEG_IDX_W-1:0]     rd_idx;
    logic                      rd_issue;
    logic                      rd_release;

    // Write qualification: beats into a still-full bank are dropped, and
    // a flush cycle ignores the input entirely.
    logic wr_en;
    logic wr_eob;

    assign wr_en  = inport_valid_i && !img_start_i && !full_q[wr_bank_q];
    assign wr_eob = wr_en && inport_eob_i;

    assign inport_blk_space_o = !(full_q[0] && full_q[1]);

`ifdef JPEG_COEF_BUF_TRANSPOSE_EN
    assign rd_idx = {rd_cnt_q[2:0], rd_cnt_q[5:3]};
`else
    assign rd_idx = rd_cnt_q;
`endif

    jpeg_coef_buf_ram u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wr_bank_q, inport_idx_i}),
        .wr_data_i (inport_data_i),
        .rd_en_i   (rd_issue),
        .rd_zero_i (!mask_q[rd_bank_q][rd_idx]),
        .rd_clr_i  (img_start_i),
        .rd_addr_i ({rd_bank_q, rd_idx}),
        .rd_data_o (outport_data_o)
    );

    // Bank flags, masks, ids and pointers. Release always targets the bank
    // being read and capture the bank being written; those differ whenever
    // both can happen, so both updates take effect in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q    <= '0;
            mask_q[0] <= '0;
            mask_q[1] <= '0;
            id_q[0]   <= '0;
            id_q[1]   <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else if (img_start_i) begin
            full_q    <= '0;
            mask_q[0] <= '0;
            mask_q[1] <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            if (rd_release) begin
                full_q[rd_bank_q] <= 1'b0;
                mask_q[rd_bank_q] <= '0;
                rd_bank_q         <= !rd_bank_q;
            end
            if (wr_en) begin
                mask_q[wr_bank_q][inport_idx_i] <= 1'b1;
                if (wr_eob) begin
                    full_q[wr_bank_q] <= 1'b1;
                    id_q[wr_bank_q]   <= inport_id_i;
                    wr_bank_q         <= !wr_bank_q;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next state: when to issue a RAM read and when to free a bank.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rd_issue   = 1'b0;
        rd_release = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = RD_LOAD;
                end
            end
            RD_LOAD: begin
                rd_issue = 1'b1;
                state_d  = RD_STREAM;
            end
            RD_STREAM: begin
                if (outport_last_o) begin
                    if (outport_accept_i) begin
                        rd_release = 1'b1;
                        state_d    = RD_IDLE;
                    end
                end else if (!outport_valid_o || outport_accept_i) begin
                    rd_issue = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (img_start_i) begin
            state_d    = RD_IDLE;
            rd_issue   = 1'b0;
            rd_release = 1'b0;
        end
    end

    // Read counter and output sideband registers, aligned with the RAM
    // read data register so all output fields move together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q        <= '0;
            outport_valid_o <= 1'b0;
            outport_idx_o   <= '0;
            outport_id_o    <= '0;
            outport_last_o  <= 1'b0;
        end else if (img_start_i) begin
            rd_cnt_q        <= '0;
            outport_valid_o <= 1'b0;
            outport_idx_o   <= '0;
            outport_id_o    <= '0;
            outport_last_o  <= 1'b0;
        end else if (rd_issue) begin
            // The count wraps to zero after 63, ready for the next block.
            rd_cnt_q        <= rd_cnt_q + 1'b1;
            outport_valid_o <= 1'b1;
            outport_idx_o   <= rd_idx;
            outport_id_o    <= id_q[rd_bank_q];
            outport_last_o  <= (rd_cnt_q == 6'd63);
        end else if (rd_release) begin
            outport_valid_o <= 1'b0;
            outport_last_o  <= 1'b0;
        end
    end

endmodule : jpeg_coef_buf

// File: tb/tb_jpeg_coef_buf.sv
// Directed bench for jpeg_coef_buf: DC-only and full blocks, backpressure,
// ping-pong occupancy, overwrite and mid-stream flush. Expected beats are
// built from hand-written block contents in raster order.
module tb_jpeg_coef_buf;

    typedef logic [15:0] blk_t [64];

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        img_start_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [15:0] inport_data_i = '0;
    logic [5:0]  inport_idx_i = '0;
    logic [31:0] inport_id_i = '0;
    logic        inport_eob_i = 1'b0;
    logic        inport_blk_space_o;
    logic        outport_valid_o;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic [31:0] outport_id_o;
    logic        outport_last_o;
    logic        outport_accept_i = 1'b0;

    int checks = 0;
    int failures = 0;

    blk_t exp_a, exp_b, exp_c;

    jpeg_coef_buf dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .img_start_i        (img_start_i),
        .inport_valid_i     (inport_valid_i),
        .inport_data_i      (inport_data_i),
        .inport_idx_i       (inport_idx_i),
        .inport_id_i        (inport_id_i),
        .inport_eob_i       (inport_eob_i),
        .inport_blk_space_o (inport_blk_space_o),
        .outport_valid_o    (outport_valid_o),
        .outport_data_o     (outport_data_o),
        .outport_idx_o      (outport_idx_o),
        .outport_id_o       (outport_id_o),
        .outport_last_o     (outport_last_o),
        .outport_accept_i   (outport_accept_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [5:0] idx, input logic [15:0] data,
                        input logic [31:0] id, input logic eob);
        inport_valid_i = 1'b1;
        inport_idx_i   = idx;
        inport_data_i  = data;
        inport_id_i    = id;
        inport_eob_i   = eob;
        step();
        inport_valid_i = 1'b0;
        inport_eob_i   = 1'b0;
    endtask

    function automatic logic [5:0] beat_idx(input logic [5:0] k);
`ifdef JPEG_COEF_BUF_TRANSPOSE_EN
        return {k[2:0], k[5:3]};
`else
        return k;
`endif
    endfunction

    function automatic blk_t zero_blk();
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = 16'h0000;
        return b;
    endfunction

    task automatic send_full_block(input logic [31:0] id);
        for (int k = 0; k < 64; k++) begin
            send(6'(k), 16'(k + 1), id, k == 63);
        end
    endtask

    // Consume one 64-beat block. Every sampled cycle, accepted or stalled,
    // must show the expected fields of the pending beat.
    task automatic drain(input string name, input blk_t exp, input logic [31:0] exp_id,
                         input bit rnd);
        int k;
        int guard;
        logic acc;
        logic [5:0] ri;
        guard = 0;
        while (!outport_valid_o && guard < 20) begin
            step();
            guard++;
        end
        if (!outport_valid_o) begin
            check({name, "_wait_valid"}, 0, 1);
            return;
        end
        k = 0;
        for (int g = 0; g < 4000 && k < 64; g++) begin
            acc = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            outport_accept_i = acc;
            ri = beat_idx(6'(k));
            check($sformatf("%s_b%0d_valid", name, k), outport_valid_o, 1);
            check($sformatf("%s_b%0d_data", name, k), outport_data_o, exp[ri]);
            check($sformatf("%s_b%0d_idx", name, k), outport_idx_o, ri);
            check($sformatf("%s_b%0d_last", name, k), outport_last_o, k == 63);
            check($sformatf("%s_b%0d_id", name, k), outport_id_o, exp_id);
            step();
            if (acc) k++;
        end
        outport_accept_i = 1'b0;
        if (k < 64) check({name, "_beats"}, k, 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) step();
        check("rst_valid", outport_valid_o, 0);
        check("rst_data", outport_data_o, 0);
        check("rst_idx", outport_idx_o, 0);
        check("rst_id", outport_id_o, 0);
        check("rst_last", outport_last_o, 0);
        check("rst_space", inport_blk_space_o, 1);
        rst_ni = 1'b1;
        step();

        // DC-only block, with the two-cycle turnaround checked.
        exp_a = zero_blk();
        exp_a[0] = 16'h0123;
        send(6'd0, 16'h0123, 32'h4000_0005, 1'b1);
        check("dc_lat0", outport_valid_o, 0);
        step();
        check("dc_lat1", outport_valid_o, 0);
        step();
        check("dc_lat2", outport_valid_o, 1);
        drain("dc", exp_a, 32'h4000_0005, 1'b0);
        check("dc_done_valid", outport_valid_o, 0);

        // Full block, row-major values 1..64.
        exp_a = zero_blk();
        for (int k = 0; k < 64; k++) exp_a[k] = 16'(k + 1);
        send_full_block(32'h8000_0011);
        check("full_lat0", outport_valid_o, 0);
        step();
        check("full_lat1", outport_valid_o, 0);
        step();
        check("full_lat2", outport_valid_o, 1);
        drain("full", exp_a, 32'h8000_0011, 1'b0);

        // Same block under random backpressure.
        send_full_block(32'hC000_0022);
        drain("bp", exp_a, 32'hC000_0022, 1'b1);
        repeat (2) step();

        // Ping-pong: two blocks captured while downstream is stalled.
        exp_a = zero_blk();
        exp_a[0] = 16'h0AAA;
        exp_b = zero_blk();
        exp_b[3] = 16'h0BBB;
        exp_c = zero_blk();
        exp_c[63] = 16'h0CCC;
        exp_c[10] = 16'h00CC;
        send(6'd0, 16'h0AAA, 32'h0000_0001, 1'b1);
        check("pp_space_after_1", inport_blk_space_o, 1);
        send(6'd3, 16'h0BBB, 32'h0000_0002, 1'b1);
        check("pp_space_after_2", inport_blk_space_o, 0);
        repeat (4) step();
        check("pp_space_stalled", inport_blk_space_o, 0);
        check("pp_valid_stalled", outport_valid_o, 1);
        drain("pp_a", exp_a, 32'h0000_0001, 1'b0);
        check("pp_space_rise", inport_blk_space_o, 1);
        send(6'd10, 16'h00CC, 32'h0000_0003, 1'b0);
        send(6'd63, 16'h0CCC, 32'h0000_0003, 1'b1);
        drain("pp_b", exp_b, 32'h0000_0002, 1'b0);
        drain("pp_c", exp_c, 32'h0000_0003, 1'b0);

        // Overwrite: last write to an index wins.
        exp_a = zero_blk();
        exp_a[5] = 16'h0009;
        exp_a[0] = 16'h0001;
        send(6'd5, 16'h0007, 32'h0000_0044, 1'b0);
        send(6'd5, 16'h0009, 32'h0000_0044, 1'b0);
        send(6'd0, 16'h0001, 32'h0000_0044, 1'b1);
        drain("ovw", exp_a, 32'h0000_0044, 1'b0);

        // Flush mid-stream with both banks full.
        send(6'd0, 16'h0111, 32'h0000_0055, 1'b1);
        send(6'd0, 16'h0222, 32'h0000_0066, 1'b1);
        check("fl_space_full", inport_blk_space_o, 0);
        step();
        check("fl_valid_up", outport_valid_o, 1);
        outport_accept_i = 1'b1;
        repeat (3) step();
        outport_accept_i = 1'b0;
        check("fl_mid_idx", outport_idx_o, beat_idx(6'd3));
        img_start_i = 1'b1;
        step();
        img_start_i = 1'b0;
        check("fl_valid_drop", outport_valid_o, 0);
        check("fl_space_back", inport_blk_space_o, 1);
        check("fl_last_clr", outport_last_o, 0);
        repeat (3) step();
        check("fl_still_idle", outport_valid_o, 0);

        // Fresh block after the flush.
        exp_a = zero_blk();
        for (int k = 0; k < 64; k++) exp_a[k] = 16'(k + 1);
        send_full_block(32'h4000_0077);
        drain("post_fl", exp_a, 32'h4000_0077, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jpeg_coef_buf
